// File: rtl/dcache_pkg.sv
// Shared types, FSM state encodings and tree-PLRU helpers for the set-associative data cache.
package dcache_pkg;

  localparam int unsigned MaxTagW  = 64;
  localparam int unsigned MaxPlruW = 7;

  typedef logic [1:0] dc_state_t;
  localparam dc_state_t StIdle      = 2'd0;
  localparam dc_state_t StWriteback = 2'd1;
  localparam dc_state_t StRefill    = 2'd2;
  localparam dc_state_t StUpdate    = 2'd3;

  // Tag field is oversized and zero-extended; only the low bits are ever non-zero.
  typedef struct packed {
    logic               valid;
    logic               dirty;
    logic [MaxTagW-1:0] tag;
  } tag_entry_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Node n has children 2n+1 (bit 0) and 2n+2 (bit 1); a bit points toward the victim.
  function automatic int unsigned plru_victim(input logic [MaxPlruW-1:0] bits,
                                              input int unsigned levels);
    int unsigned node;
    int unsigned way;
    logic        b;
    node = 0;
    way  = 0;
    for (int unsigned l = 0; l < 3; l++) begin
      if (l < levels) begin
        b    = bits[node[2:0]];
        way  = (way << 1) | 32'(b);
        node = 2 * node + 1 + 32'(b);
      end
    end
    return way;
  endfunction

  function automatic logic [MaxPlruW-1:0] plru_update(input logic [MaxPlruW-1:0] bits,
                                                      input int unsigned way,
                                                      input int unsigned levels);
    logic [MaxPlruW-1:0] r;
    int unsigned         node;
    logic                d;
    r    = bits;
    node = 0;
    for (int unsigned l = 0; l < 3; l++) begin
      if (l < levels) begin
        d              = 1'((way >> (levels - 1 - l)) & 32'd1);
        r[node[2:0]]   = ~d;
        node           = 2 * node + 1 + 32'(d);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dcache_sram_nway.sv
// Per-way tag and line storage with combinational read and hit-way compare.
module dcache_sram_nway
  import dcache_pkg::*;
#(
  parameter int unsigned WAYS   = 2,
  parameter int unsigned SETS   = 16,
  parameter int unsigned LINE_W = 256,
  localparam int unsigned IdxW  = $clog2(SETS),
  localparam int unsigned WayW  = clog2_min1(WAYS)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [IdxW-1:0]              idx_i,
  input  logic [MaxTagW-1:0]           tag_i,
  input  logic [WayW-1:0]              we_way_i,
  input  logic                         tag_we_i,
  input  tag_entry_t                   tag_wdata_i,
  input  logic                         data_we_i,
  input  logic [LINE_W-1:0]            data_wdata_i,
  output tag_entry_t [WAYS-1:0]        rd_entry_o,
  output logic [WAYS-1:0][LINE_W-1:0]  rd_line_o,
  output logic                         hit_o,
  output logic [WayW-1:0]              hit_way_o
);

  tag_entry_t        tag_mem  [WAYS][SETS];
  logic [LINE_W-1:0] line_mem [WAYS][SETS];

  // Only valid/dirty are cleared; stale tags are harmless once valid is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          tag_mem[w][s].valid <= 1'b0;
          tag_mem[w][s].dirty <= 1'b0;
        end
      end
    end else if (tag_we_i) begin
      tag_mem[we_way_i][idx_i] <= tag_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (data_we_i) begin
      line_mem[we_way_i][idx_i] <= data_wdata_i;
    end
  end

  always_comb begin
    hit_o     = 1'b0;
    hit_way_o = '0;
    for (int w = 0; w < WAYS; w++) begin
      rd_entry_o[w] = tag_mem[w][idx_i];
      rd_line_o[w]  = line_mem[w][idx_i];
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (tag_mem[w][idx_i].valid && (tag_mem[w][idx_i].tag == tag_i)) begin
        hit_o     = 1'b1;
        hit_way_o = WayW'(w);
      end
    end
  end

endmodule

// File: rtl/dcache_setassoc_ctrl.sv
// Write-back, write-allocate set-associative data cache controller with tree-PLRU replacement.
// Optional hit/miss counters are enabled by defining DCACHE_PERF_CNT_EN.
module dcache_setassoc_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned WAYS   = 2,
  parameter int unsigned SETS   = 16,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int unsigned OffW   = $clog2(LINE_W / 8);
  localparam int unsigned IdxW   = $clog2(SETS);
  localparam int unsigned TagW   = ADDR_W - IdxW - OffW;
  localparam int unsigned WordW  = OffW - 2;
  localparam int unsigned WayW   = clog2_min1(WAYS);
  localparam int unsigned Levels = $clog2(WAYS);
  localparam int unsigned PlruW  = (WAYS > 1) ? WAYS - 1 : 1;

  dc_state_t         state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [31:0]       req_data_q, req_data_d;
  logic              req_wr_q, req_wr_d;
  logic [WayW-1:0]   victim_q, victim_d;
  logic [PlruW-1:0]  plru_q [SETS];
  logic [PlruW-1:0]  plru_d [SETS];

  logic [ADDR_W-1:0]            cur_addr;
  logic [IdxW-1:0]              idx;
  logic [TagW-1:0]              tag;
  logic [WordW-1:0]             word;
  logic [MaxTagW-1:0]           tag_ext;
  tag_entry_t [WAYS-1:0]        rd_entry;
  logic [WAYS-1:0][LINE_W-1:0]  rd_line;
  logic                         hit;
  logic [WayW-1:0]              hit_way, victim_sel, we_way;
  logic                         tag_we, data_we, req, hit_acc, miss_acc;
  tag_entry_t                   tag_wdata;
  logic [LINE_W-1:0]            data_wdata;
  logic                         unused_bits;

  // Outside IDLE the lookup follows the latched miss address.
  assign cur_addr = (state_q == StIdle) ? cpu_addr_i : req_addr_q;
  assign idx      = cur_addr[OffW +: IdxW];
  assign tag      = cur_addr[ADDR_W-1 -: TagW];
  assign word     = cur_addr[2 +: WordW];
  assign tag_ext  = MaxTagW'(tag);
  assign req      = cpu_MemRead_i | cpu_MemWrite_i;
  assign unused_bits = ^{cpu_addr_i[1:0], req_addr_q[1:0], rd_entry};

  dcache_sram_nway #(
    .WAYS   (WAYS),
    .SETS   (SETS),
    .LINE_W (LINE_W)
  ) u_sram (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .idx_i        (idx),
    .tag_i        (tag_ext),
    .we_way_i     (we_way),
    .tag_we_i     (tag_we),
    .tag_wdata_i  (tag_wdata),
    .data_we_i    (data_we),
    .data_wdata_i (data_wdata),
    .rd_entry_o   (rd_entry),
    .rd_line_o    (rd_line),
    .hit_o        (hit),
    .hit_way_o    (hit_way)
  );

  always_comb begin
    victim_sel = WayW'(plru_victim(MaxPlruW'(plru_q[idx]), Levels));
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!rd_entry[w].valid) victim_sel = WayW'(w);
    end
  end

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    req_data_d   = req_data_q;
    req_wr_d     = req_wr_q;
    victim_d     = victim_q;
    plru_d       = plru_q;
    tag_we       = 1'b0;
    data_we      = 1'b0;
    we_way       = hit_way;
    tag_wdata    = '0;
    data_wdata   = rd_line[hit_way];
    cpu_stall_o  = 1'b0;
    cpu_data_o   = '0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    hit_acc      = 1'b0;
    miss_acc     = 1'b0;
    case (state_q)
      StIdle: begin
        if (req && hit) begin
          hit_acc     = 1'b1;
          plru_d[idx] = PlruW'(plru_update(MaxPlruW'(plru_q[idx]), 32'(hit_way), Levels));
          if (cpu_MemWrite_i) begin
            data_we                    = 1'b1;
            data_wdata[32*word +: 32]  = cpu_data_i;
            tag_we                     = 1'b1;
            tag_wdata                  = '{valid: 1'b1, dirty: 1'b1, tag: tag_ext};
          end else begin
            cpu_data_o = rd_line[hit_way][32*word +: 32];
          end
        end else if (req) begin
          cpu_stall_o = 1'b1;
          miss_acc    = 1'b1;
          req_addr_d  = cpu_addr_i;
          req_data_d  = cpu_data_i;
          req_wr_d    = cpu_MemWrite_i;
          victim_d    = victim_sel;
          state_d     = (rd_entry[victim_sel].valid && rd_entry[victim_sel].dirty) ?
                        StWriteback : StRefill;
        end
      end
      StWriteback: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {rd_entry[victim_q].tag[TagW-1:0], idx, {OffW{1'b0}}};
        mem_data_o   = rd_line[victim_q];
        if (mem_ack_i) state_d = StRefill;
      end
      StRefill: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {tag, idx, {OffW{1'b0}}};
        we_way       = victim_q;
        if (mem_ack_i) begin
          data_we     = 1'b1;
          data_wdata  = mem_data_i;
          tag_we      = 1'b1;
          tag_wdata   = '{valid: 1'b1, dirty: 1'b0, tag: tag_ext};
          plru_d[idx] = PlruW'(plru_update(MaxPlruW'(plru_q[idx]), 32'(victim_q), Levels));
          state_d     = StUpdate;
        end
      end
      default: begin
        // Merging the latched store here is idempotent with the replayed hit.
        cpu_stall_o = 1'b1;
        we_way      = victim_q;
        data_wdata  = rd_line[victim_q];
        if (req_wr_q) begin
          data_we                   = 1'b1;
          data_wdata[32*word +: 32] = req_data_q;
          tag_we                    = 1'b1;
          tag_wdata                 = '{valid: 1'b1, dirty: 1'b1, tag: tag_ext};
        end
        state_d = StIdle;
      end
    endcase
    if (rst_i) begin
      tag_we       = 1'b0;
      data_we      = 1'b0;
      cpu_stall_o  = 1'b0;
      cpu_data_o   = '0;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      hit_acc      = 1'b0;
      miss_acc     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_wr_q   <= 1'b0;
      victim_q   <= '0;
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      req_wr_q   <= req_wr_d;
      victim_q   <= victim_d;
      plru_q     <= plru_d;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_acc && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_d  = hit_cnt_q + 32'd1;
    if (miss_acc && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = hit_acc ^ miss_acc;
`endif

endmodule

// File: tb/tb_dcache_setassoc_ctrl.sv
// Directed bench for dcache_setassoc_ctrl at default parameters with a latency-configurable memory.
module tb_dcache_setassoc_ctrl;

  localparam int unsigned LineW = 256;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      cpu_addr, cpu_wdata, cpu_rdata;
  logic             cpu_rd, cpu_wr, cpu_stall;
  logic [31:0]      mem_addr;
  logic [LineW-1:0] mem_wdata, mem_rdata;
  logic             mem_en, mem_we, mem_ack;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]      hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  dcache_setassoc_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cpu_addr_i     (cpu_addr),
    .cpu_data_i     (cpu_wdata),
    .cpu_MemRead_i  (cpu_rd),
    .cpu_MemWrite_i (cpu_wr),
    .cpu_data_o     (cpu_rdata),
    .cpu_stall_o    (cpu_stall),
    .mem_addr_o     (mem_addr),
    .mem_data_o     (mem_wdata),
    .mem_enable_o   (mem_en),
    .mem_write_o    (mem_we),
    .mem_data_i     (mem_rdata),
    .mem_ack_i      (mem_ack)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_cnt_o      (hit_cnt),
    .miss_cnt_o     (miss_cnt)
`endif
  );

  logic [LineW-1:0] mem_model [64];
  logic [LineW-1:0] line0_init, exp_line;
  int               lat = 2;
  int               cnt = 0;
  int               n_wb = 0, n_rf = 0, rf_at_wb = 0, rf_snap;
  logic [31:0]      last_wb_addr = '0, last_rf_addr = '0;
  logic [LineW-1:0] last_wb_data = '0;
  int               n_tests = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [LineW-1:0] obs, input logic [LineW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks after 'lat' enabled cycles, abandons on reset.
  always @(negedge clk) begin
    if (rst || !mem_en || mem_ack) begin
      mem_ack = 1'b0;
      cnt     = 0;
    end else begin
      cnt++;
      if (cnt >= lat) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          mem_model[mem_addr[10:5]] = mem_wdata;
          n_wb++;
          rf_at_wb     = n_rf;
          last_wb_addr = mem_addr;
          last_wb_data = mem_wdata;
        end else begin
          mem_rdata    = mem_model[mem_addr[10:5]];
          n_rf++;
          last_rf_addr = mem_addr;
        end
      end
    end
  end

  task automatic access(input logic [31:0] addr, input logic rd, input logic wr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic first_stall);
    int stalls;
    @(negedge clk);
    cpu_addr  = addr;
    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_wdata = wdata;
    #1;
    first_stall = cpu_stall;
    stalls      = 0;
    while (cpu_stall && stalls < 200) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (stalls >= 200) check_eq("access_timeout", cpu_stall, 0);
    rdata = cpu_rdata;
    @(posedge clk);
    #1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [31:0] rdata;
  logic        fst;

  initial begin
    rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 64; i++)
      for (int k = 0; k < 8; k++)
        mem_model[i][32*k +: 32] = 32'hA000_0000 | (32'(i) << 16) | 32'(k);
    for (int j = 0; j < 16; j++) mem_model[0][16*j +: 16] = 16'((15 - j) * 16'h1111);
    line0_init = mem_model[0];
    do_reset();

    @(negedge clk); #1;
    check_eq("rst_stall", cpu_stall, 0);
    check_eq("rst_mem_en", mem_en, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_data", mem_wdata, 0);
    check_eq("rst_cpu_data", cpu_rdata, 0);

    // Cold read miss
    access(32'h0000, 1, 0, 0, rdata, fst);
    check_eq("cold_first_stall", fst, 1);
    check_eq("cold_data", rdata, 32'hEEEE_FFFF);
    check_eq("cold_refills", n_rf, 1);
    check_eq("cold_refill_addr", last_rf_addr, 32'h0000);
    check_eq("cold_no_wb", n_wb, 0);

    // Store hit then readback
    access(32'h0004, 0, 1, 32'hDEAD_BEEF, rdata, fst);
    check_eq("st_hit_no_stall", fst, 0);
    access(32'h0004, 1, 0, 0, rdata, fst);
    check_eq("ld_hit_no_stall", fst, 0);
    check_eq("ld_hit_data", rdata, 32'hDEAD_BEEF);
`ifdef DCACHE_PERF_CNT_EN
    check_eq("hit_cnt", hit_cnt, 3);
    check_eq("miss_cnt", miss_cnt, 1);
`endif

    // Read+write together acts as a store
    access(32'h0008, 1, 1, 32'h1234_5678, rdata, fst);
    check_eq("rw_no_stall", fst, 0);
    check_eq("rw_no_load_data", rdata, 0);
    access(32'h0008, 1, 0, 0, rdata, fst);
    check_eq("rw_readback", rdata, 32'h1234_5678);

    // Conflict writeback of the dirty line at 0x0000
    access(32'h0200, 1, 0, 0, rdata, fst);
    check_eq("c1_miss", fst, 1);
    check_eq("c1_no_wb", n_wb, 0);
    check_eq("c1_data", rdata, 32'hA010_0000);
    access(32'h0400, 1, 0, 0, rdata, fst);
    exp_line = line0_init;
    exp_line[63:32] = 32'hDEAD_BEEF;
    exp_line[95:64] = 32'h1234_5678;
    check_eq("c2_wb_count", n_wb, 1);
    check_eq("c2_wb_addr", last_wb_addr, 32'h0000);
    check_eq("c2_wb_data", last_wb_data, exp_line);
    check_eq("c2_refill_after_wb", n_rf, rf_at_wb + 1);
    check_eq("c2_refill_addr", last_rf_addr, 32'h0400);
    check_eq("c2_data", rdata, 32'hA020_0000);

    // PLRU: 0x0200 must be the victim of the 0x0400 fill
    do_reset();
    access(32'h0000, 1, 0, 0, rdata, fst);
    access(32'h0200, 1, 0, 0, rdata, fst);
    access(32'h0000, 1, 0, 0, rdata, fst);
    check_eq("plru_rehit", fst, 0);
    access(32'h0400, 1, 0, 0, rdata, fst);
    check_eq("plru_fill_miss", fst, 1);
    access(32'h0000, 1, 0, 0, rdata, fst);
    check_eq("plru_keep_hit", fst, 0);
    check_eq("plru_keep_data", rdata, 32'hEEEE_FFFF);
    access(32'h0200, 1, 0, 0, rdata, fst);
    check_eq("plru_evicted_miss", fst, 1);

    // Reset two cycles into a 10-cycle refill
    lat = 10;
    @(negedge clk);
    cpu_addr = 32'h0600; cpu_rd = 1'b1;
    #1;
    check_eq("mr_miss_stall", cpu_stall, 1);
    rf_snap = n_rf;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("mr_refill_active", mem_en, 1);
    rst = 1'b1; cpu_rd = 1'b0;
    #1;
    check_eq("mr_rst_en_low", mem_en, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check_eq("mr_idle_en", mem_en, 0);
    check_eq("mr_idle_stall", cpu_stall, 0);
    check_eq("mr_no_ack", n_rf, rf_snap);
    lat = 2;
    access(32'h0000, 1, 0, 0, rdata, fst);
    check_eq("mr_post_miss", fst, 1);
    check_eq("mr_post_data", rdata, 32'hEEEE_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
